// File: rtl/bob_rx_fifo_if.sv
// Handshake bundle between the bob receiver's plaintext output, the rx FIFO and its user.
// slave is the FIFO side; master is the side that feeds and drains it.
interface bob_rx_fifo_if #(
   parameter int ADDR_W = 3
);
   logic [127:0]    dec_data;
   logic            dec_valid;
   logic            dec_stb;
   logic [127:0]    out_data;
   logic            out_valid;
   logic            out_ready;
   logic [ADDR_W:0] level;
   logic            full;
   logic            empty;
   logic [31:0]     blk_cnt;

   modport master (
      output dec_data, dec_valid, out_ready,
      input  dec_stb, out_data, out_valid, level, full, empty, blk_cnt
   );

   modport slave (
      input  dec_data, dec_valid, out_ready,
      output dec_stb, out_data, out_valid, level, full, empty, blk_cnt
   );
endinterface

// File: rtl/bob_rx_fifo.sv
// First-word-fall-through receive FIFO behind the bob decryptor, with an acknowledge holdoff.
// Optional BOB_RX_FLUSH_EN adds a synchronous flush input that empties the FIFO.
module bob_rx_fifo #(
   parameter int DEPTH   = 8,
   parameter int ADDR_W  = 3,
   parameter int HOLDOFF = 2
) (
   input  logic clk,
   input  logic reset,
`ifdef BOB_RX_FLUSH_EN
   input  logic flush,
`endif
   bob_rx_fifo_if.slave bus
);
   localparam logic [ADDR_W:0]   FULL_LEVEL = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0]   LEVEL_ONE  = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
   localparam logic [3:0]        HOLD_LOAD  = 4'(HOLDOFF);

   logic [127:0]    mem_r [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_r;
   logic [ADDR_W-1:0] rd_ptr_r;
   logic [ADDR_W:0] level_r;
   logic [ADDR_W:0] level_nxt_s;
   logic [3:0]      hold_cnt_r;
   logic [31:0]     blk_cnt_r;
   logic            full_r;
   logic            empty_r;
   logic            valid_r;
   logic            push_s;
   logic            pop_s;
   logic            flush_s;

`ifdef BOB_RX_FLUSH_EN
   assign flush_s = flush;
`else
   assign flush_s = 1'b0;
`endif

   // Accept/consume decisions; nothing is acknowledged while reset is held so a pending block survives it.
   always_comb begin
      push_s = 1'b0;
      pop_s  = 1'b0;
      if (reset && !flush_s) begin
         push_s = bus.dec_valid & ~full_r & (hold_cnt_r == 4'd0);
         pop_s  = valid_r & bus.out_ready;
      end else begin
         push_s = 1'b0;
         pop_s  = 1'b0;
      end
   end

   // Next occupancy; the flags are registered from this value.
   always_comb begin
      level_nxt_s = level_r;
      if (flush_s) begin
         level_nxt_s = {(ADDR_W + 1){1'b0}};
      end else begin
         case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + LEVEL_ONE;
            2'b01:   level_nxt_s = level_r - LEVEL_ONE;
            default: level_nxt_s = level_r;
         endcase
      end
   end

   // Pointers, occupancy flags, holdoff timer and block counter.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_r   <= {ADDR_W{1'b0}};
         rd_ptr_r   <= {ADDR_W{1'b0}};
         level_r    <= {(ADDR_W + 1){1'b0}};
         full_r     <= 1'b0;
         empty_r    <= 1'b1;
         valid_r    <= 1'b0;
         hold_cnt_r <= 4'd0;
         blk_cnt_r  <= 32'd0;
      end else begin
         if (flush_s) begin
            wr_ptr_r <= {ADDR_W{1'b0}};
            rd_ptr_r <= {ADDR_W{1'b0}};
         end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         level_r <= level_nxt_s;
         full_r  <= (level_nxt_s == FULL_LEVEL);
         empty_r <= (level_nxt_s == {(ADDR_W + 1){1'b0}});
         valid_r <= (level_nxt_s != {(ADDR_W + 1){1'b0}});
         // Holdoff masks the upstream valid while it is still deasserting after our strobe.
         if (push_s) begin
            hold_cnt_r <= HOLD_LOAD;
         end else if (hold_cnt_r != 4'd0) begin
            hold_cnt_r <= hold_cnt_r - 4'd1;
         end else begin
            hold_cnt_r <= hold_cnt_r;
         end
         if (push_s) blk_cnt_r <= blk_cnt_r + 32'd1;
      end
   end

   // Block storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push_s) mem_r[wr_ptr_r] <= bus.dec_data;
   end

   assign bus.dec_stb   = push_s;
   assign bus.out_data  = mem_r[rd_ptr_r];
   assign bus.out_valid = valid_r;
   assign bus.level     = level_r;
   assign bus.full      = full_r;
   assign bus.empty     = empty_r;
   assign bus.blk_cnt   = blk_cnt_r;
endmodule

// File: tb/tb_bob_rx_fifo.sv
// Self-checking bench for bob_rx_fifo: directed scenarios plus random traffic against a queue model.
module tb_bob_rx_fifo;
   localparam int DEPTH   = 8;
   localparam int ADDR_W  = 3;
   localparam int HOLDOFF = 2;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic flush = 1'b0;
   int   total = 0;
   int   bad = 0;

   bit [127:0] q [$];
   int         since;
   int         blk;
   int         popped;
   bit         last_push;

   bob_rx_fifo_if #(.ADDR_W(ADDR_W)) bif ();

   bob_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .HOLDOFF(HOLDOFF)) dut (
      .clk   (clk),
      .reset (reset),
`ifdef BOB_RX_FLUSH_EN
      .flush (flush),
`endif
      .bus   (bif.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      blk    = 0;
      popped = 0;
      since  = HOLDOFF + 1;
      last_push = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #2;
      chk("stb_in_reset", 128'(bif.dec_stb), 128'(0));
      @(posedge clk);
      #1;
      reset = 1'b1;
      model_reset();
   endtask

   // One clock: drive, compare against the model just before the edge, then advance the model.
   task automatic step(input logic v, input logic [127:0] d, input logic r, input logic fl);
      bit exp_push;
      bit exp_pop;
      bif.dec_valid = v;
      bif.dec_data  = d;
      bif.out_ready = r;
      flush = fl;
      #2;
      exp_push = v && !fl && (q.size() < DEPTH) && (since > HOLDOFF);
      exp_pop  = r && !fl && (q.size() > 0);
      chk("dec_stb",   128'(bif.dec_stb),   128'(exp_push));
      chk("out_valid", 128'(bif.out_valid), 128'(q.size() != 0));
      chk("level",     128'(bif.level),     128'(q.size()));
      chk("full",      128'(bif.full),      128'(q.size() == DEPTH));
      chk("empty",     128'(bif.empty),     128'(q.size() == 0));
      chk("blk_cnt",   128'(bif.blk_cnt),   128'(32'(blk)));
      if (q.size() > 0) chk("out_data", bif.out_data, q[0]);
      @(posedge clk);
      #1;
      if (fl) begin
         q.delete();
      end else begin
         if (exp_pop) begin
            void'(q.pop_front());
            popped++;
         end
         if (exp_push) begin
            q.push_back(d);
            blk++;
         end
      end
      since = exp_push ? 1 : ((since < 100) ? since + 1 : since);
      last_push = exp_push;
   endtask

   initial begin
      logic [127:0] cur;
      logic [127:0] up_d;
      logic         up_v;
      int           pushed;
      int           n;
      int           stb_cycles [$];

      bif.dec_valid = 1'b0;
      bif.dec_data  = 128'd0;
      bif.out_ready = 1'b0;
      model_reset();

      // Reset release with a block already waiting
      bif.dec_valid = 1'b1;
      bif.dec_data  = 128'd1;
      bif.out_ready = 1'b1;
      do_reset();
      step(1'b1, 128'd1, 1'b1, 1'b0);
      chk("first_out_valid", 128'(bif.out_valid), 128'd1);
      chk("first_out_data",  bif.out_data,        128'd1);
      chk("first_blk_cnt",   128'(bif.blk_cnt),   128'd1);
      step(1'b0, 128'd0, 1'b1, 1'b0);

      // Valid held high with constant data: strobes every HOLDOFF+1 cycles
      do_reset();
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 128'hAA, 1'b0, 1'b0);
         if (last_push) stb_cycles.push_back(i);
      end
      chk("holdoff_pulses", 128'(stb_cycles.size()), 128'd4);
      for (int i = 0; i < stb_cycles.size(); i++)
         chk("holdoff_cycle", 128'(stb_cycles[i]), 128'(i * (HOLDOFF + 1)));

      // Fill to DEPTH with 0x10..0x17
      do_reset();
      cur = 128'h10;
      pushed = 0;
      n = 0;
      while (pushed < DEPTH && n < 100) begin
         step(1'b1, cur, 1'b0, 1'b0);
         if (last_push) begin
            cur = cur + 128'd1;
            pushed++;
         end
         n++;
      end
      chk("fill_count", 128'(pushed), 128'(DEPTH));
      for (int i = 0; i < 3; i++) step(1'b1, 128'h18, 1'b0, 1'b0);
      chk("fill_full",  128'(bif.full),  128'd1);
      chk("fill_level", 128'(bif.level), 128'(DEPTH));
      // Pop while full: the offered push waits one cycle
      step(1'b1, 128'h18, 1'b1, 1'b0);
      chk("pop_full_level", 128'(bif.level), 128'd7);
      step(1'b1, 128'h18, 1'b0, 1'b0);
      chk("refill_level", 128'(bif.level), 128'(DEPTH));
      n = 0;
      while (q.size() > 0 && n < 40) begin
         step(1'b0, 128'd0, 1'b1, 1'b0);
         n++;
      end
      chk("drain_empty", 128'(bif.empty), 128'd1);

      // Twenty blocks with out_ready toggling
      do_reset();
      pushed = 0;
      n = 0;
      while ((pushed < 20 || q.size() > 0) && n < 400) begin
         step(pushed < 20, 128'h100 + 128'(pushed), (n % 2) == 0, 1'b0);
         if (last_push) pushed++;
         n++;
      end
      chk("stream_blk_cnt", 128'(bif.blk_cnt), 128'd20);
      chk("stream_popped",  128'(popped),      128'd20);

      // Random traffic with a mid-stream reset
      do_reset();
      up_v = 1'b0;
      up_d = 128'd0;
      for (int i = 0; i < 600; i++) begin
         if (i == 300) do_reset();
         if (!up_v) begin
            up_v = ($urandom_range(0, 3) != 0);
            up_d = {$urandom(), $urandom(), $urandom(), $urandom()};
         end
         step(up_v, up_d, ($urandom_range(0, 2) != 0), 1'b0);
         if (last_push) up_v = 1'b0;
      end

`ifdef BOB_RX_FLUSH_EN
      // Flush at level 5 while a block is offered
      do_reset();
      n = 0;
      while (q.size() < 5 && n < 60) begin
         step(1'b1, 128'(n), 1'b0, 1'b0);
         n++;
      end
      chk("pre_flush_level", 128'(bif.level), 128'd5);
      n = blk;
      for (int i = 0; i < HOLDOFF; i++) step(1'b0, 128'd0, 1'b0, 1'b0);
      step(1'b1, 128'h55, 1'b0, 1'b1);
      chk("flush_empty",   128'(bif.empty),   128'd1);
      chk("flush_blk_cnt", 128'(bif.blk_cnt), 128'(32'(n)));
      step(1'b1, 128'h55, 1'b1, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/bob_rx_fifo.md
Name: bob_rx_fifo

Overview:
- Receive-side buffer directly downstream of the bob receiver's plaintext output (data / data_valid / usr_o_stb).
- Pulls decrypted 128-bit blocks, acknowledging each with a one-cycle strobe, and stores them in a first-word-fall-through FIFO.
- Presents blocks to the user over a valid/ready handshake and keeps a running count of accepted blocks.
- Lets the user side stall without stalling the decryptor beyond FIFO capacity.

Parameters:
- DEPTH, 8, FIFO depth in 128-bit blocks; power of 2, minimum 2.
- ADDR_W, 3, log2(DEPTH).
- HOLDOFF, 2, cycles after an acknowledge during which dec_valid is ignored; covers upstream valid-deassert latency; range 1..15.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- dec_data  in  128  decrypted block from receiver.
- dec_valid  in  1  dec_data valid; held by upstream until acknowledged.
- dec_stb  out  1  one-cycle acknowledge to upstream (drives usr_o_stb).
- out_data  out  128  head-of-FIFO block.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  user consumes head when out_valid & out_ready.
- level  out  ADDR_W+1  current occupancy, 0..DEPTH.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- blk_cnt  out  32  total blocks accepted since reset.

Behaviour:
- Reset (reset==0 at posedge):
  - rd/wr pointers = 0, level = 0, empty = 1, full = 0, out_valid = 0.
  - dec_stb = 0, holdoff counter = 0, blk_cnt = 0.
  - out_data contents are don't-care.
  - Reset mid-transfer discards all stored blocks; an upstream block still held valid is re-accepted once holdoff allows after reset release.
- Accept condition (combinational): push = dec_valid & ~full & (hold_cnt == 0).
- dec_stb = push, combinational, asserted in the same cycle dec_data is written. Exactly one dec_stb pulse per stored block.
- Holdoff:
  - On push, hold_cnt loads HOLDOFF; it decrements by 1 each cycle while nonzero.
  - A valid held high through holdoff therefore yields at most one push per HOLDOFF+1 cycles.
- Pop: pop = out_valid & out_ready; the rd pointer advances at the posedge.
- Level and flags:
  - level' = level + push - pop.
  - Simultaneous push and pop: level unchanged, both pointers advance.
  - When full, push = 0 even if a pop happens in the same cycle; the pop frees the slot for the next cycle.
  - When empty, pop cannot occur because out_valid = 0.
  - full, empty and out_valid are registered, derived from level'.
- Latency: a push into an empty FIFO makes out_valid = 1 with out_data = that block on the next cycle.
- out_data always equals the memory entry at the rd pointer (FWFT). Data order is strictly preserved.
- Pointers are ADDR_W bits and wrap modulo DEPTH.
- blk_cnt increments by 1 on each push and wraps 0xFFFFFFFF -> 0 with no flag.
- No overflow is possible by construction; upstream simply waits while full.

Optional Feature:
- Macro: BOB_RX_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit).
  - flush==1 at a posedge: pointers = 0, level = 0, empty = 1, out_valid = 0 next cycle.
  - Flush has priority over push and pop in the same cycle. No dec_stb is issued in a flush cycle (push forced 0).
  - blk_cnt and hold_cnt are not changed by flush.
- Undefined: no flush port; behaviour otherwise identical.

Test Plan:
- Reset release with dec_valid=1, dec_data=0x...0001, out_ready=1 -> dec_stb high in first active cycle; next cycle out_valid=1, out_data=0x...0001; blk_cnt=1.
- dec_valid held high with constant data, HOLDOFF=2, out_ready=0 -> dec_stb pulses on cycles 0, 3, 6, ...; level increments by 1 per pulse.
- Push 8 blocks 0x10..0x17 with out_ready=0 -> full=1, level=8, further dec_valid gets no dec_stb. Raise out_ready -> outputs 0x10..0x17 in order, with a one-cycle gap at the full boundary before the next push.
- While full, pop and offer a push in the same cycle -> push blocked that cycle, level=7; next eligible cycle push accepted, level=8.
- Continuous traffic of 20 blocks with out_ready toggling 1,0 -> every block delivered once, in order, pointers wrapped; blk_cnt=20.
- (BOB_RX_FLUSH_EN) level=5, flush pulse with dec_valid=1 -> no dec_stb that cycle, empty=1 next cycle, blk_cnt unchanged.
